// File: rtl/io_bridge_pkg.sv
// Shared constants for the I/O bridge: offsets, window base, reset glyphs and hex glyph table.
package io_bridge_pkg;

    localparam logic [9:0]  LED_OFFSET    = 10'h360;
    localparam logic [9:0]  SWITCH_OFFSET = 10'h370;
    localparam logic [9:0]  SEG_OFFSET    = 10'h380;
    localparam logic [21:0] IO_BASE       = 22'h3FFFFF;

    localparam logic [7:0] SEG_BLANK       = 8'hFF;
    localparam logic [7:0] SEG_RESET_EN    = 8'hFE;
    localparam logic [7:0] SEG_RESET_GLYPH = 8'hC0;

    // Active-low {dp,g..a}; element 0 is the glyph for nibble 0.
    localparam logic [15:0][7:0] HEX_GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] hex_glyph(input logic [3:0] nibble);
        return HEX_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/io_bridge_switch_debouncer.sv
// Two-flop synchronizer plus saturating debounce counter over a whole switch vector.
module switch_debouncer #(
    parameter int unsigned WIDTH           = 24,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out
);

    localparam logic [15:0] COUNT_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [15:0]      cnt_q, cnt_d;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else begin
            if (cnt_q != COUNT_LAST) begin
                cnt_d = cnt_q + 16'd1;
            end
            // Accept on the edge the count lands on its terminal value.
            if (cnt_d == COUNT_LAST) begin
                stable_d = cand_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_out = stable_q;

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: LED register, debounced switches and optional seven-segment scanner.
// The seg data register and scanner are built only when IO_BRIDGE_SEG_EN is defined.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] SCAN_DIV        = 16'd20000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [9:0]  addr_low,
    input  logic [31:0] write_data,
    input  logic [31:0] mem_read_data,
    output logic [31:0] read_data,
    input  logic [23:0] switch_in,
    output logic [23:0] led_out,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);

    logic [23:0] led_q, led_d;
    logic [23:0] switch_reg;

    switch_debouncer #(
        .WIDTH          (24),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_switch_debouncer (
        .clock     (clock),
        .reset     (reset),
        .raw_in    (switch_in),
        .stable_out(switch_reg)
    );

    always_comb begin
        led_d = led_q;
        if (io_write && (addr_low == LED_OFFSET)) begin
            led_d = write_data[23:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_out = led_q;

`ifdef IO_BRIDGE_SEG_EN
    logic [31:0] seg_data_q, seg_data_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  digit_q, digit_d;
    logic [3:0]  nibble;

    always_comb begin
        seg_data_d = seg_data_q;
        if (io_write && (addr_low == SEG_OFFSET)) begin
            seg_data_d = write_data;
        end
        div_d   = div_q + 16'd1;
        digit_d = digit_q;
        if (div_q == SCAN_DIV - 16'd1) begin
            div_d   = '0;
            digit_d = digit_q + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seg_data_q <= '0;
            div_q      <= '0;
            digit_q    <= '0;
        end else begin
            seg_data_q <= seg_data_d;
            div_q      <= div_d;
            digit_q    <= digit_d;
        end
    end

    assign nibble  = seg_data_q[{digit_q, 2'b00} +: 4];
    assign seg_en  = ~(8'b1 << digit_q);
    assign seg_out = hex_glyph(nibble);
`else
    assign seg_en  = SEG_BLANK;
    assign seg_out = SEG_BLANK;
`endif

    // Reads see pre-edge register values, so a same-cycle write returns the old word.
    always_comb begin
        read_data = 32'h0;
        if (io_read) begin
            unique case (addr_low)
                LED_OFFSET:    read_data = {8'h0, led_q};
                SWITCH_OFFSET: read_data = {8'h0, switch_reg};
`ifdef IO_BRIDGE_SEG_EN
                SEG_OFFSET:    read_data = seg_data_q;
`endif
                default:       read_data = 32'h0;
            endcase
        end else if (mem_read) begin
            read_data = mem_read_data;
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Randomized self-checking bench for io_bridge against a queue-based behavioural model.
module tb_io_bridge;

    localparam int DC = 4;
    localparam int SD = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        io_read = 1'b0;
    logic        io_write = 1'b0;
    logic [9:0]  addr_low = '0;
    logic [31:0] write_data = '0;
    logic [31:0] mem_read_data = '0;
    logic [31:0] read_data;
    logic [23:0] switch_in = '0;
    logic [23:0] led_out;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;

    io_bridge #(
        .DEBOUNCE_CYCLES(16'(DC)),
        .SCAN_DIV       (16'(SD))
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_read     (mem_read),
        .io_read      (io_read),
        .io_write     (io_write),
        .addr_low     (addr_low),
        .write_data   (write_data),
        .mem_read_data(mem_read_data),
        .read_data    (read_data),
        .switch_in    (switch_in),
        .led_out      (led_out),
        .seg_en       (seg_en),
        .seg_out      (seg_out)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    // Model state
    logic [23:0] led_m, sw_m, raw_prev;
    logic [31:0] seg_m;
    logic [23:0] seen[$];
    int          tick;

    task check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [31:0] exp_read();
        if (io_read) begin
            if (addr_low == 10'h360) return {8'h0, led_m};
            if (addr_low == 10'h370) return {8'h0, sw_m};
`ifdef IO_BRIDGE_SEG_EN
            if (addr_low == 10'h380) return seg_m;
`endif
            return 32'h0;
        end
        if (mem_read) return mem_read_data;
        return 32'h0;
    endfunction

    task check_outputs();
        int digit;
        check_eq("read_data", read_data, exp_read());
        check_eq("led_out", {8'h0, led_out}, {8'h0, led_m});
`ifdef IO_BRIDGE_SEG_EN
        digit = (tick / SD) % 8;
        check_eq("seg_en", {24'h0, seg_en}, {24'h0, ~(8'h01 << digit)});
        check_eq("seg_out", {24'h0, seg_out}, {24'h0, glyph(seg_m[digit*4 +: 4])});
`else
        digit = 0;
        check_eq("seg_en", {24'h0, seg_en}, 32'hFF);
        check_eq("seg_out", {24'h0, seg_out}, 32'hFF);
`endif
    endtask

    // A value is accepted once the synchronized input has shown it for DC straight cycles.
    task model_edge();
        bit same;
        if (reset) begin
            led_m = '0; seg_m = '0; sw_m = '0; raw_prev = '0; tick = 0;
            seen.delete();
            seen.push_back(24'h0);
        end else begin
            if (io_write && addr_low == 10'h360) led_m = write_data[23:0];
`ifdef IO_BRIDGE_SEG_EN
            if (io_write && addr_low == 10'h380) seg_m = write_data;
`endif
            if (seen.size() >= DC) begin
                same = 1'b1;
                for (int i = seen.size() - DC; i < seen.size(); i++)
                    if (seen[i] != seen[$]) same = 1'b0;
                if (same) sw_m = seen[$];
            end
            seen.push_back(raw_prev);
            if (seen.size() > DC + 1) void'(seen.pop_front());
            raw_prev = switch_in;
            tick++;
        end
    endtask

    task cycle();
        #1;
        if (checking) check_outputs();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task idle();
        reset = 0; mem_read = 0; io_read = 0; io_write = 0;
    endtask

    task do_reset();
        idle(); reset = 1; cycle(); reset = 0;
    endtask

    initial begin
        int hold;
        @(posedge clock);
        #1;
        do_reset();
        checking = 1'b1;

        // Reset state
        check_eq("rst_led", {8'h0, led_out}, 32'h0);
`ifdef IO_BRIDGE_SEG_EN
        check_eq("rst_seg_en", {24'h0, seg_en}, 32'hFE);
        check_eq("rst_seg_out", {24'h0, seg_out}, 32'hC0);
`else
        check_eq("rst_seg_en", {24'h0, seg_en}, 32'hFF);
`endif

        // LED write then readback
        io_write = 1; addr_low = 10'h360; write_data = 32'h00A5A5A5; cycle();
        idle(); io_read = 1; cycle();
        check_eq("led_write", {8'h0, led_out}, 32'h00A5A5A5);
        check_eq("led_read", read_data, 32'h00A5A5A5);

        // Simultaneous read/write returns the pre-write value
        io_read = 1; io_write = 1; write_data = 32'h00123456; #1;
        check_eq("rw_old_val", read_data, 32'h00A5A5A5);
        cycle(); idle();

        // Reset wins over a same-cycle write
        reset = 1; io_write = 1; addr_low = 10'h360; write_data = 32'h00FFFFFF; cycle(); idle();
        check_eq("rst_over_wr", {8'h0, led_out}, 32'h0);
        mem_read = 1; mem_read_data = 32'hDEADBEEF; #1;
        check_eq("mem_read", read_data, 32'hDEADBEEF);
        cycle(); idle();
        io_read = 1; addr_low = 10'h3F0; #1;
        check_eq("unmapped_rd", read_data, 32'h0);
        cycle(); idle();

        // Clean switch step
        do_reset();
        switch_in = 24'h00000F; io_read = 1; addr_low = 10'h370;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check_eq("sw_step", read_data, (k <= 5) ? 32'h0 : 32'h0000000F);
        end

        // Short glitch never lands
        do_reset(); switch_in = '0;
        for (int k = 0; k < 8; k++) cycle();
        io_read = 1; addr_low = 10'h370; switch_in = 24'h1;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) switch_in = 24'h0;
            cycle();
            check_eq("sw_glitch", read_data, 32'h0);
        end

        // Seg data write and scanning
        idle(); io_write = 1; addr_low = 10'h380; write_data = 32'h76543210; cycle();
        idle(); io_read = 1;
        for (int k = 0; k < 20; k++) cycle();
`ifndef IO_BRIDGE_SEG_EN
        check_eq("seg_unmapped", read_data, 32'h0);
        check_eq("seg_en_tied", {24'h0, seg_en}, 32'hFF);
`endif

        // Randomized traffic
        hold = 0;
        for (int n = 0; n < 800; n++) begin
            idle();
            reset = ($urandom_range(0, 63) == 0);
            mem_read = $urandom_range(0, 1);
            io_read = $urandom_range(0, 1);
            io_write = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: addr_low = 10'h360;
                1: addr_low = 10'h370;
                2: addr_low = 10'h380;
                3: addr_low = 10'h3F0;
                default: addr_low = 10'($urandom);
            endcase
            write_data = $urandom;
            mem_read_data = $urandom;
            if (hold == 0) begin
                switch_in = ($urandom_range(0, 1) != 0) ? 24'($urandom) : 24'($urandom_range(0, 3));
                hold = $urandom_range(1, 2 * DC);
            end
            hold--;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles needed before a synchronized switch change is accepted; legal range 2..65535.
REQ-002 Parameter SCAN_DIV, 16'd20000: clock cycles each seven-segment digit is held; legal range 2..65535.
REQ-003 clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_read  in  1  data-memory load strobe from the controller.
REQ-006 io_read  in  1  I/O load strobe; address lies in 0xFFFFFC00..0xFFFFFFFF.
REQ-007 io_write  in  1  I/O store strobe; same address window.
REQ-008 addr_low  in  10  ALU result bits [9:0] (I/O offset).
REQ-009 write_data  in  32  register rt value being stored.
REQ-010 mem_read_data  in  32  data-memory read word.
REQ-011 read_data  out  32  word returned to register write-back.
REQ-012 switch_in  in  24  raw asynchronous board switches.
REQ-013 led_out  out  24  board LEDs, active-high.
REQ-014 seg_en  out  8  digit enables, one-hot active-low.
REQ-015 seg_out  out  8  segments {dp,g..a}, active-low.

Function
REQ-016 Offset map on addr_low: 10'h360 LED register (R/W, bits [23:0]); 10'h370 switch register (R only, bits [23:0]); 10'h380 seg data register (R/W, 32 bits).
REQ-017 read_data SHALL be combinational: io_read -> selected I/O register zero-extended to 32 bits; else mem_read -> mem_read_data; else 32'h0.
REQ-018 io_read to an unmapped or write-only offset SHALL return 32'h0; io_write to an unmapped or read-only offset SHALL change no state.
REQ-019 io_write to 10'h360 SHALL load write_data[23:0] into led_out on that edge; visible next cycle; led_out is the register, no further delay.
REQ-020 switch_in SHALL pass a 2-flop synchronizer; raw-to-synchronized latency 2 cycles.
REQ-021 Debounce: counter clears whenever the synchronized value differs from a candidate register (candidate reloaded); counter saturates; when it reaches DEBOUNCE_CYCLES-1 the candidate copies into the switch register.
REQ-022 Total switch latency for a clean step: exactly 2 + DEBOUNCE_CYCLES cycles; a glitch shorter than DEBOUNCE_CYCLES cycles SHALL never reach the switch register.
REQ-023 Scanner: divider counts 0..SCAN_DIV-1 then wraps; on wrap the digit index advances 0..7, wrapping 7->0.
REQ-024 Digit index i SHALL drive seg_en = ~(8'b1<<i) and seg_out = active-low hex glyph of seg data nibble [4i+3:4i], dp off (1).
REQ-025 io_read and io_write asserted together (illegal) SHALL still perform the write and return the pre-write value on read_data.

Reset
REQ-026 reset SHALL override every concurrent event, including io_write in the same cycle.
REQ-027 After reset: led_out 24'h0, seg data 32'h0, synchronizer/candidate/switch registers 24'h0, debounce counter 0, scan divider 0, digit index 0, so seg_en 8'hFE and seg_out 8'hC0.
REQ-028 reset asserted mid-debounce or mid-scan SHALL abandon the operation with no partial update.

Configuration
REQ-029 Macro IO_BRIDGE_SEG_EN: defined -> seg data register and scanner compiled in per REQ-023/024.
REQ-030 Undefined -> no seg register or scanner logic; offset 10'h380 treated as unmapped; seg_en tied 8'hFF, seg_out tied 8'hFF.

Structure
REQ-031 Shared package SHALL hold I/O offset constants (LED, switch, seg), the I/O window base 22'h3FFFFF, reset glyph constants and the 16-entry hex-to-segment table.
REQ-032 One sub-module, switch_debouncer (synchronizer + debounce counter, width-parameterized), SHALL be instantiated once for all 24 bits.

Verification
REQ-033 reset, io_write=1, addr_low=10'h360, write_data=32'h00A5A5A5 -> next cycle led_out=24'hA5A5A5; io_read same offset -> read_data=32'h00A5A5A5.
REQ-034 DEBOUNCE_CYCLES=4, switch_in 0->24'h00000F held -> read at 10'h370 returns 0 through cycle 5, 32'h0000000F from cycle 6.
REQ-035 DEBOUNCE_CYCLES=4, switch_in pulses 24'h1 for 3 cycles then 0 -> switch register stays 0 throughout.
REQ-036 IO_BRIDGE_SEG_EN defined, SCAN_DIV=2, seg data written 32'h76543210 -> seg_en walks FE,FD,...,7F,FE every 2 cycles; digit 0 seg_out=C0, digit 1 seg_out=F9.
REQ-037 io_write to 10'h360 with reset=1 same cycle -> led_out stays 24'h0; mem_read=1, io_read=0, mem_read_data=32'hDEADBEEF -> read_data=32'hDEADBEEF.
REQ-038 io_read at 10'h3F0 -> read_data=32'h0; macro undefined, io_write 10'h380 -> no state change, seg_en=8'hFF.
